// File: rtl/pkt_unpack.sv
// Serial-to-parallel unpacker for 8-word radio frames: validates the packet type,
// guards against stalled senders, and holds each complete frame until the consumer acks it.
module pkt_unpack #(
   parameter int unsigned WORD_WIDTH = 16,
   parameter int unsigned TIMEOUT = 16,
   parameter logic [WORD_WIDTH-1:0] BCAST_ID = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  en,
   input  logic                  in_valid,
   input  logic [WORD_WIDTH-1:0] in_word,
   output logic                  in_ready,
   input  logic [WORD_WIDTH-1:0] myNodeID,
   input  logic                  out_ack,
   output logic [WORD_WIDTH-1:0] fPacketType,
   output logic [WORD_WIDTH-1:0] fSourceID,
   output logic [WORD_WIDTH-1:0] fDestinationID,
   output logic [WORD_WIDTH-1:0] fEnergyLeft,
   output logic [WORD_WIDTH-1:0] fQValue,
   output logic [WORD_WIDTH-1:0] fSourceHops,
   output logic [WORD_WIDTH-1:0] fChosenCH,
   output logic [WORD_WIDTH-1:0] fHopsFromCH,
   output logic                  f_valid,
   output logic                  iAmDestination,
   output logic                  err_type,
   output logic                  err_timeout
);

   localparam int unsigned GW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] StIdle = 2'd0;
   localparam logic [1:0] StRecv = 2'd1;
   localparam logic [1:0] StHold = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [2:0]            idx_q, idx_d;
   logic [GW-1:0]         gap_q, gap_d;
   logic                  bad_q, bad_d;
   logic                  accept, load, clr_valid, err_type_d, err_timeout_d;
   logic [WORD_WIDTH-1:0] wbuf_q [8];

   assign in_ready = en && (state_q != StHold);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      gap_d         = gap_q;
      bad_d         = bad_q;
      load          = 1'b0;
      clr_valid     = 1'b0;
      err_type_d    = 1'b0;
      err_timeout_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StRecv;
               idx_d   = 3'd1;
               gap_d   = '0;
               bad_d   = in_word > WORD_WIDTH'(6);
            end
         end
         StRecv: begin
            if (!en) begin
               // Silent abort: partial frame is simply forgotten.
               state_d = StIdle;
               idx_d   = '0;
               gap_d   = '0;
            end else if (accept) begin
               gap_d = '0;
               if (idx_q == 3'd7) begin
                  idx_d = '0;
                  if (bad_q) begin
                     state_d    = StIdle;
                     err_type_d = 1'b1;
                  end else begin
                     state_d = StHold;
                     load    = 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end else if (gap_q == GW'(TIMEOUT - 1)) begin
               state_d       = StIdle;
               idx_d         = '0;
               gap_d         = '0;
               err_timeout_d = 1'b1;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end
         StHold: begin
            if (out_ack) begin
               state_d   = StIdle;
               clr_valid = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q        <= StIdle;
         idx_q          <= '0;
         gap_q          <= '0;
         bad_q          <= 1'b0;
         err_type       <= 1'b0;
         err_timeout    <= 1'b0;
         f_valid        <= 1'b0;
         iAmDestination <= 1'b0;
         fPacketType    <= '0;
         fSourceID      <= '0;
         fDestinationID <= '0;
         fEnergyLeft    <= '0;
         fQValue        <= '0;
         fSourceHops    <= '0;
         fChosenCH      <= '0;
         fHopsFromCH    <= '0;
         for (int i = 0; i < 8; i++) wbuf_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         gap_q       <= gap_d;
         bad_q       <= bad_d;
         err_type    <= err_type_d;
         err_timeout <= err_timeout_d;
         if (accept) wbuf_q[idx_q] <= in_word;
         // Word 7 is taken straight from the bus so all fields update in one edge.
         if (load) begin
            f_valid        <= 1'b1;
            iAmDestination <= (wbuf_q[2] == myNodeID) || (wbuf_q[2] == BCAST_ID);
            fPacketType    <= wbuf_q[0];
            fSourceID      <= wbuf_q[1];
            fDestinationID <= wbuf_q[2];
            fEnergyLeft    <= wbuf_q[3];
            fQValue        <= wbuf_q[4];
            fSourceHops    <= wbuf_q[5];
            fChosenCH      <= wbuf_q[6];
            fHopsFromCH    <= in_word;
         end else if (clr_valid) begin
            f_valid        <= 1'b0;
            iAmDestination <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pkt_unpack.sv
// Directed self-checking bench for pkt_unpack: decode, broadcast, bad type,
// timeout, mid-frame reset and enable drop.
module tb_pkt_unpack;

   logic        clk, nrst, en, in_valid, in_ready, out_ack;
   logic [15:0] in_word, myNodeID;
   logic [15:0] fPacketType, fSourceID, fDestinationID, fEnergyLeft;
   logic [15:0] fQValue, fSourceHops, fChosenCH, fHopsFromCH;
   logic        f_valid, iAmDestination, err_type, err_timeout;

   int n_checks = 0;
   int n_fail   = 0;
   logic [15:0] frame [8];

   pkt_unpack dut (
      .clk(clk), .nrst(nrst), .en(en), .in_valid(in_valid), .in_word(in_word),
      .in_ready(in_ready), .myNodeID(myNodeID), .out_ack(out_ack),
      .fPacketType(fPacketType), .fSourceID(fSourceID), .fDestinationID(fDestinationID),
      .fEnergyLeft(fEnergyLeft), .fQValue(fQValue), .fSourceHops(fSourceHops),
      .fChosenCH(fChosenCH), .fHopsFromCH(fHopsFromCH), .f_valid(f_valid),
      .iAmDestination(iAmDestination), .err_type(err_type), .err_timeout(err_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drives frame[0..n-1]; on return we sit at the negedge after the last accept.
   task automatic send_words(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_word  = frame[i];
         if (i == 7) chk("no_early_valid", {31'd0, f_valid}, 32'd0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_word  = 16'h0;
   endtask

   task automatic ack;
      @(negedge clk);
      out_ack = 1'b1;
      @(negedge clk);
      out_ack = 1'b0;
   endtask

   initial begin
      nrst = 1'b0; en = 1'b1; in_valid = 1'b0; in_word = '0; out_ack = 1'b0;
      myNodeID = 16'h0005;
      #12;
      chk("rst_f_valid", {31'd0, f_valid}, 32'd0);
      chk("rst_fields", {fPacketType, fHopsFromCH}, 32'd0);
      chk("rst_errs", {30'd0, err_type, err_timeout}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      nrst = 1'b1;

      // Basic decode addressed to this node
      frame = '{16'd3, 16'h0002, 16'h0005, 16'h0064, 16'h0010, 16'd2, 16'h0007, 16'd1};
      send_words(8);
      chk("t1_valid", {31'd0, f_valid}, 32'd1);
      chk("t1_type", {16'd0, fPacketType}, 32'd3);
      chk("t1_src", {16'd0, fSourceID}, 32'h2);
      chk("t1_dst", {16'd0, fDestinationID}, 32'h5);
      chk("t1_energy", {16'd0, fEnergyLeft}, 32'h64);
      chk("t1_q", {16'd0, fQValue}, 32'h10);
      chk("t1_shops", {16'd0, fSourceHops}, 32'd2);
      chk("t1_ch", {16'd0, fChosenCH}, 32'h7);
      chk("t1_hops", {16'd0, fHopsFromCH}, 32'd1);
      chk("t1_iamdst", {31'd0, iAmDestination}, 32'd1);
      chk("t1_ready_hold", {31'd0, in_ready}, 32'd0);
      // HOLD ignores en and persists without ack
      en = 1'b0;
      repeat (3) @(negedge clk);
      en = 1'b1;
      chk("t1_hold_valid", {31'd0, f_valid}, 32'd1);
      chk("t1_hold_ready", {31'd0, in_ready}, 32'd0);
      ack();
      chk("t1_ack_valid", {31'd0, f_valid}, 32'd0);
      chk("t1_ack_iamdst", {31'd0, iAmDestination}, 32'd0);
      chk("t1_ack_ready", {31'd0, in_ready}, 32'd1);
      chk("t1_ack_retain", {16'd0, fPacketType}, 32'd3);

      // Broadcast, then foreign destination
      frame[2] = 16'hFFFF;
      send_words(8);
      chk("t2_bcast_iamdst", {31'd0, iAmDestination}, 32'd1);
      ack();
      frame[2] = 16'h0009;
      send_words(8);
      chk("t2_other_valid", {31'd0, f_valid}, 32'd1);
      chk("t2_other_iamdst", {31'd0, iAmDestination}, 32'd0);
      ack();
      chk("t2_ack_valid", {31'd0, f_valid}, 32'd0);
      chk("t2_ack_dst", {16'd0, fDestinationID}, 32'h9);

      // Illegal packet type: consumed, dropped, flagged
      frame = '{16'd7, 16'h0001, 16'h0005, 16'h0003, 16'h0004, 16'd5, 16'h0006, 16'd8};
      send_words(8);
      chk("t3_err_type", {31'd0, err_type}, 32'd1);
      chk("t3_no_tmo", {31'd0, err_timeout}, 32'd0);
      chk("t3_no_valid", {31'd0, f_valid}, 32'd0);
      chk("t3_keep_dst", {16'd0, fDestinationID}, 32'h9);
      chk("t3_keep_type", {16'd0, fPacketType}, 32'd3);
      @(negedge clk);
      chk("t3_pulse_end", {31'd0, err_type}, 32'd0);

      // Inter-word timeout after 3 words
      frame = '{16'd2, 16'h0011, 16'h0005, 16'h0021, 16'h0031, 16'd4, 16'h0041, 16'd6};
      send_words(3);
      repeat (15) @(negedge clk);
      chk("t4_tmo_early", {31'd0, err_timeout}, 32'd0);
      @(negedge clk);
      chk("t4_tmo_pulse", {31'd0, err_timeout}, 32'd1);
      chk("t4_tmo_no_type", {31'd0, err_type}, 32'd0);
      chk("t4_tmo_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      chk("t4_tmo_end", {31'd0, err_timeout}, 32'd0);
      send_words(8);
      chk("t4_valid", {31'd0, f_valid}, 32'd1);
      chk("t4_type", {16'd0, fPacketType}, 32'd2);
      chk("t4_src", {16'd0, fSourceID}, 32'h11);
      chk("t4_hops", {16'd0, fHopsFromCH}, 32'd6);
      ack();

      // Reset mid-frame after word 4
      frame = '{16'd1, 16'h00A1, 16'h0005, 16'h00A3, 16'h00A4, 16'd9, 16'h00A6, 16'd3};
      send_words(5);
      nrst = 1'b0;
      #1;
      chk("t5_rst_type", {16'd0, fPacketType}, 32'd0);
      chk("t5_rst_dst", {16'd0, fDestinationID}, 32'd0);
      chk("t5_rst_flags", {28'd0, f_valid, iAmDestination, err_type, err_timeout}, 32'd0);
      @(negedge clk);
      nrst = 1'b1;
      send_words(8);
      chk("t5_valid", {31'd0, f_valid}, 32'd1);
      chk("t5_type", {16'd0, fPacketType}, 32'd1);
      chk("t5_src", {16'd0, fSourceID}, 32'hA1);
      chk("t5_hops", {16'd0, fHopsFromCH}, 32'd3);
      ack();

      // Enable drop mid-frame after word 2
      frame = '{16'd6, 16'h00B1, 16'h0005, 16'h00B3, 16'h00B4, 16'd7, 16'h00B6, 16'd2};
      send_words(3);
      en = 1'b0;
      #1;
      chk("t6_ready_off", {31'd0, in_ready}, 32'd0);
      repeat (20) begin
         @(negedge clk);
         chk("t6_no_err", {30'd0, err_type, err_timeout}, 32'd0);
      end
      en = 1'b1;
      send_words(8);
      chk("t6_valid", {31'd0, f_valid}, 32'd1);
      chk("t6_type", {16'd0, fPacketType}, 32'd6);
      chk("t6_src", {16'd0, fSourceID}, 32'hB1);
      chk("t6_shops", {16'd0, fSourceHops}, 32'd7);
      chk("t6_hops", {16'd0, fHopsFromCH}, 32'd2);
      chk("t6_iamdst", {31'd0, iAmDestination}, 32'd1);
      ack();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pkt_unpack.md
PKT_UNPACK -- requirements
Module: pkt_unpack

Interface
REQ-001 Parameter WORD_WIDTH, default 16: width of every packet word and field.
REQ-002 Parameter TIMEOUT, default 16: max consecutive idle cycles allowed between words inside a frame.
REQ-003 Parameter BCAST_ID, default 16'hFFFF: broadcast destination ID.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  block enable.
REQ-007 in_valid  input  1  in_word carries a valid packet word.
REQ-008 in_word  input  WORD_WIDTH  serial packet word from radio interface.
REQ-009 in_ready  output  1  block can accept a word this cycle.
REQ-010 myNodeID  input  WORD_WIDTH  this node's ID.
REQ-011 out_ack  input  1  consumer (packetFilter) has taken the held fields.
REQ-012 fPacketType, fSourceID, fDestinationID, fEnergyLeft, fQValue, fSourceHops, fChosenCH, fHopsFromCH  output  WORD_WIDTH each  unpacked fields.
REQ-013 f_valid  output  1  fields hold a complete, accepted frame.
REQ-014 iAmDestination  output  1  held frame addressed to this node or broadcast.
REQ-015 err_type  output  1  one-cycle pulse: frame dropped, illegal packet type.
REQ-016 err_timeout  output  1  one-cycle pulse: frame aborted on inter-word timeout.

Function
REQ-017 Frame SHALL be exactly 8 words, in order: packetType, sourceID, destinationID, energyLeft, QValue, sourceHops, chosenCH, hopsFromCH.
REQ-018 Word SHALL be accepted only in a cycle where in_valid=1 and in_ready=1.
REQ-019 States SHALL be IDLE, RECV, HOLD; 3-bit word index, gap counter sized for TIMEOUT.
REQ-020 in_ready SHALL be combinational: 1 in IDLE or RECV when en=1; 0 in HOLD or when en=0.
REQ-021 IDLE: accepted word is word 0 -> RECV, index=1.
REQ-022 RECV: each accept stores word at current index, index increments, gap counter clears.
REQ-023 Word-0 value above 6 SHALL set an internal bad-type flag; remaining 7 words are still consumed to keep frame alignment.
REQ-024 Accept of word 7 with bad-type clear: next cycle state=HOLD, f_valid=1, all eight f* outputs and iAmDestination updated together.
REQ-025 Accept of word 7 with bad-type set: next cycle state=IDLE, err_type=1 for one cycle, f* outputs and f_valid unchanged.
REQ-026 iAmDestination SHALL be registered as (destinationID==myNodeID) OR (destinationID==BCAST_ID), using myNodeID in the word-7 accept cycle.
REQ-027 f* outputs SHALL only change on frame completion (REQ-024) or reset; partial frames never visible.
REQ-028 HOLD: out_ack=1 -> next cycle f_valid=0, iAmDestination=0, state=IDLE; f* fields retain values.
REQ-029 HOLD: out_ack=0 -> remain in HOLD indefinitely, f_valid held at 1; en has no effect in HOLD.
REQ-030 out_ack outside HOLD SHALL be ignored.
REQ-031 RECV: each cycle with no accept increments gap counter; after TIMEOUT consecutive such cycles state=IDLE, index=0, err_timeout=1 for next cycle only.
REQ-032 en=0 while in RECV SHALL abort to IDLE next cycle, discard partial frame, no error pulse.
REQ-033 err_type and err_timeout SHALL never be asserted in the same cycle.
REQ-034 Latency: f_valid rises exactly 1 cycle after word-7 accept; minimum frame-to-frame spacing = 8 accepts + 1 HOLD cycle + ack.

Reset
REQ-035 nrst=0 SHALL immediately force state=IDLE, index=0, gap counter=0, bad-type=0, all f* outputs=0, f_valid=0, iAmDestination=0, err_type=0, err_timeout=0.
REQ-036 Reset mid-frame or in HOLD SHALL discard all frame data; first word after reset release is treated as word 0.

Verification
REQ-037 en=1, myNodeID=16'h0005, 8 back-to-back words {3,0x0002,0x0005,0x0064,0x0010,2,0x0007,1} -> f_valid=1 one cycle after last word, fPacketType=3, fDestinationID=5, iAmDestination=1, in_ready=0 until out_ack.
REQ-038 Same frame with destinationID=16'hFFFF, then 0x0009 -> iAmDestination=1, then 0; out_ack -> f_valid=0 next cycle, fields retained.
REQ-039 Frame with packetType=7 -> all 8 words accepted, no f_valid, err_type pulse 1 cycle after word 7, previous fields unchanged.
REQ-040 3 words then in_valid=0 for 16 cycles -> err_timeout pulse, state IDLE; next 8-word frame decoded correctly.
REQ-041 Assert nrst=0 after word 4 of a frame -> all outputs 0 immediately; fresh frame after release decodes from word 0.
REQ-042 en dropped after word 2 -> no error pulse, in_ready=0; en restored, full frame decodes normally.
